// File: rtl/branch_pkg.sv
// Shared types and helpers for the KGP-RISC branch unit:
// branch opcodes, flag bit positions and the condition decoder.
package branch_pkg;

    typedef enum logic [3:0] {
        BR_NONE = 4'd0,
        BR_B    = 4'd1,
        BR_BL   = 4'd2,
        BR_BR   = 4'd3,
        BR_RET  = 4'd4,
        BR_BZ   = 4'd5,
        BR_BNZ  = 4'd6,
        BR_BLTZ = 4'd7,
        BR_BGEZ = 4'd8,
        BR_BCY  = 4'd9,
        BR_BNCY = 4'd10,
        BR_BOV  = 4'd11,
        BR_BNOV = 4'd12
    } br_op_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } br_state_t;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_S = 2;
    localparam int FLAG_V = 3;

    // Unconditional ops always take; unknown codes never do.
    function automatic logic cond_taken(input br_op_t op, input logic [3:0] f);
        case (op)
            BR_B, BR_BL, BR_BR, BR_RET: cond_taken = 1'b1;
            BR_BZ:   cond_taken = f[FLAG_Z];
            BR_BNZ:  cond_taken = !f[FLAG_Z];
            BR_BLTZ: cond_taken = f[FLAG_S];
            BR_BGEZ: cond_taken = !f[FLAG_S];
            BR_BCY:  cond_taken = f[FLAG_C];
            BR_BNCY: cond_taken = !f[FLAG_C];
            BR_BOV:  cond_taken = f[FLAG_V];
            BR_BNOV: cond_taken = !f[FLAG_V];
            default: cond_taken = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/branch_if.sv
// Bundle between decode/ALU (master) and the branch unit (slave):
// flag load, branch request and the fetch-side redirect/flush.
interface branch_if #(
    parameter int ADDR_W = 32,
    parameter int OFF_W  = 16,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              flag_we;
    logic [3:0]        flags_in;
    logic              br_valid;
    logic [3:0]        br_op;
    logic [ADDR_W-1:0] pc;
    logic [OFF_W-1:0]  imm;
    logic [ADDR_W-1:0] rs_val;
    logic              busy;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              flush;
    logic              ras_err;
    logic [3:0]        flags_q;
    logic [CNT_W-1:0]  ras_count;

    modport master (
        output flag_we, flags_in, br_valid, br_op, pc, imm, rs_val,
        input  busy, redirect_valid, redirect_pc, flush, ras_err,
        input  flags_q, ras_count
    );

    modport slave (
        input  flag_we, flags_in, br_valid, br_op, pc, imm, rs_val,
        output busy, redirect_valid, redirect_pc, flush, ras_err,
        output flags_q, ras_count
    );
endinterface

// File: rtl/branch_unit_ras_stack.sv
// Circular return-address stack: a full push overwrites the oldest
// entry, popping an empty stack is ignored (caller flags underflow).
module ras_stack #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [ADDR_W-1:0]            push_data,
    output logic [ADDR_W-1:0]            top,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  ptr;

    assign top   = mem[ptr - PTR_W'(1)];
    assign empty = (count == '0);

    // Entry storage; stale slots are harmless because count guards them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[ptr] <= push_data;
        end
    end

    // Write pointer and occupancy, saturating at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr   <= '0;
            count <= '0;
        end else if (push) begin
            ptr <= ptr + PTR_W'(1);
            if (count != CNT_W'(DEPTH)) begin
                count <= count + CNT_W'(1);
            end
        end else if (pop && !empty) begin
            ptr   <= ptr - PTR_W'(1);
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/branch_unit.sv
// Branch resolution: flag register, condition check, target select,
// RAS call/return and a registered redirect plus flush window.
module branch_unit
    import branch_pkg::*;
#(
    parameter int                ADDR_W       = 32,
    parameter int                OFF_W        = 16,
    parameter int                INSTR_BYTES  = 4,
    parameter int                DEPTH        = 4,
    parameter int                FLUSH_CYCLES = 2,
    parameter logic [ADDR_W-1:0] RESET_PC     = '0
) (
    input  logic     clk,
    input  logic     rst,
    branch_if.slave  bus
);
    localparam int CW = $clog2(FLUSH_CYCLES) + 1;

    br_state_t         state;
    logic [CW-1:0]     cnt;
    br_op_t            op;
    logic              accept;
    logic              taken;
    logic              push;
    logic              pop;
    logic              ras_empty;
    logic              underflow;
    logic [ADDR_W-1:0] ras_top;
    logic [ADDR_W-1:0] rel_tgt;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] link;

    assign op      = br_op_t'(bus.br_op);
    assign accept  = bus.br_valid && !bus.busy;
    assign taken   = accept && cond_taken(op, bus.flags_q);
    assign push    = taken && (op == BR_BL);
    assign pop     = taken && (op == BR_RET);
    assign underflow = pop && ras_empty;
    assign link    = bus.pc + ADDR_W'(INSTR_BYTES);
    assign rel_tgt = bus.pc
                   + {{(ADDR_W-OFF_W){bus.imm[OFF_W-1]}}, bus.imm};

    // Pick the redirect address for the op being resolved.
    always_comb begin
        target = rel_tgt;
        case (op)
            BR_BR:   target = bus.rs_val;
            BR_RET:  target = ras_empty ? RESET_PC : ras_top;
            default: target = rel_tgt;
        endcase
    end

    ras_stack #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (link),
        .top       (ras_top),
        .count     (bus.ras_count),
        .empty     (ras_empty)
    );

    // Flag register loads whenever asked, independent of the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.flags_q <= '0;
        end else if (bus.flag_we) begin
            bus.flags_q <= bus.flags_in;
        end
    end

    // Redirect/flush FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= ST_IDLE;
            cnt                <= '0;
            bus.busy           <= 1'b0;
            bus.flush          <= 1'b0;
            bus.redirect_valid <= 1'b0;
            bus.redirect_pc    <= '0;
            bus.ras_err        <= 1'b0;
        end else begin
            bus.redirect_valid <= 1'b0;
            bus.ras_err        <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (taken) begin
                        state              <= ST_FLUSH;
                        cnt                <= CW'(FLUSH_CYCLES - 1);
                        bus.busy           <= 1'b1;
                        bus.flush          <= 1'b1;
                        bus.redirect_valid <= 1'b1;
                        bus.redirect_pc    <= target;
                        bus.ras_err        <= underflow;
                    end
                end
                ST_FLUSH: begin
                    if (cnt == '0) begin
                        state     <= ST_IDLE;
                        bus.busy  <= 1'b0;
                        bus.flush <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit: a cycle-by-cycle vector table
// followed by RAS overflow/underflow and mid-flush reset sequences.
module tb_branch_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    branch_if #(.ADDR_W(32), .OFF_W(16), .DEPTH(4)) bus ();

    branch_unit #(
        .ADDR_W       (32),
        .OFF_W        (16),
        .INSTR_BYTES  (4),
        .DEPTH        (4),
        .FLUSH_CYCLES (2),
        .RESET_PC     (32'h0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        fwe;
        logic [3:0]  fin;
        logic        bv;
        logic [3:0]  op;
        logic [31:0] pc;
        logic [15:0] imm;
        logic [31:0] rs;
        logic        rv;
        logic [31:0] rpc;
        logic        busy;
        logic        err;
        logic [3:0]  fq;
        logic [2:0]  cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        logic fwe, logic [3:0] fin, logic bv, logic [3:0] op,
        logic [31:0] pc, logic [15:0] imm, logic [31:0] rs,
        logic rv, logic [31:0] rpc, logic busy, logic err,
        logic [3:0] fq, logic [2:0] cnt);
        vec_t v;
        v.fwe = fwe; v.fin = fin; v.bv = bv; v.op = op;
        v.pc = pc; v.imm = imm; v.rs = rs;
        v.rv = rv; v.rpc = rpc; v.busy = busy; v.err = err;
        v.fq = fq; v.cnt = cnt;
        return v;
    endfunction

    function automatic vec_t idl(logic busy, logic [3:0] fq, logic [2:0] cnt);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, busy, 0, fq, cnt);
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic fwe, input logic [3:0] fin,
                         input logic bv, input logic [3:0] op,
                         input logic [31:0] pc, input logic [15:0] imm,
                         input logic [31:0] rs);
        bus.flag_we  = fwe;
        bus.flags_in = fin;
        bus.br_valid = bv;
        bus.br_op    = op;
        bus.pc       = pc;
        bus.imm      = imm;
        bus.rs_val   = rs;
    endtask

    // One request, capture the T+1 outputs, then wait out the flush.
    task automatic issue(input logic [3:0] op, input logic [31:0] pc,
                         output logic rv, output logic [31:0] rpc,
                         output logic err);
        drive(0, 0, 1, op, pc, 16'h0, 32'h0);
        step();
        rv  = bus.redirect_valid;
        rpc = bus.redirect_pc;
        err = bus.ras_err;
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 8 && bus.busy; k++) step();
        if (bus.busy) begin
            errors++;
            $display("FAIL busy_timeout: busy still 1 after 8 cycles");
        end
    endtask

    logic        rv;
    logic [31:0] rpc;
    logic        err;

    initial begin
        vecs.push_back(mk(1, 4'b0100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h4, 0));
        vecs.push_back(mk(0, 0, 1, 7, 32'h100, 16'h10, 0, 1, 32'h110, 1, 0, 4'h4, 0));
        vecs.push_back(idl(1, 4'h4, 0));
        vecs.push_back(idl(0, 4'h4, 0));
        vecs.push_back(mk(0, 0, 1, 8, 32'h100, 16'h10, 0, 0, 0, 0, 0, 4'h4, 0));
        vecs.push_back(mk(1, 4'b0001, 1, 5, 32'h400, 16'h20, 0, 0, 0, 0, 0, 4'h1, 0));
        vecs.push_back(mk(0, 0, 1, 5, 32'h400, 16'h20, 0, 1, 32'h420, 1, 0, 4'h1, 0));
        vecs.push_back(idl(1, 4'h1, 0));
        vecs.push_back(idl(0, 4'h1, 0));
        vecs.push_back(mk(0, 0, 1, 2, 32'h200, 16'h40, 0, 1, 32'h240, 1, 0, 4'h1, 1));
        vecs.push_back(idl(1, 4'h1, 1));
        vecs.push_back(idl(0, 4'h1, 1));
        vecs.push_back(mk(0, 0, 1, 2, 32'h300, 16'hFFF0, 0, 1, 32'h2F0, 1, 0, 4'h1, 2));
        vecs.push_back(idl(1, 4'h1, 2));
        vecs.push_back(idl(0, 4'h1, 2));
        vecs.push_back(mk(0, 0, 1, 4, 0, 0, 0, 1, 32'h304, 1, 0, 4'h1, 1));
        vecs.push_back(idl(1, 4'h1, 1));
        vecs.push_back(idl(0, 4'h1, 1));
        vecs.push_back(mk(0, 0, 1, 4, 0, 0, 0, 1, 32'h204, 1, 0, 4'h1, 0));
        vecs.push_back(idl(1, 4'h1, 0));
        vecs.push_back(idl(0, 4'h1, 0));
        vecs.push_back(mk(0, 0, 1, 3, 0, 0, 32'hABC, 1, 32'hABC, 1, 0, 4'h1, 0));
        vecs.push_back(mk(0, 0, 1, 5, 32'h500, 16'h4, 0, 0, 0, 1, 0, 4'h1, 0));
        vecs.push_back(mk(0, 0, 1, 5, 32'h500, 16'h4, 0, 0, 0, 0, 0, 4'h1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 32'hFFFFFFFC, 16'h8, 0, 1, 32'h4, 1, 0, 4'h1, 0));
        vecs.push_back(idl(1, 4'h1, 0));
        vecs.push_back(idl(0, 4'h1, 0));
        vecs.push_back(mk(0, 0, 1, 4, 0, 0, 0, 1, 32'h0, 1, 1, 4'h1, 0));
        vecs.push_back(idl(1, 4'h1, 0));
        vecs.push_back(idl(0, 4'h1, 0));
        vecs.push_back(mk(0, 0, 1, 13, 32'h100, 16'h10, 0, 0, 0, 0, 0, 4'h1, 0));

        drive(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        step();
        step();
        chk("rst busy", 32'(bus.busy), 0);
        chk("rst flush", 32'(bus.flush), 0);
        chk("rst rv", 32'(bus.redirect_valid), 0);
        chk("rst rpc", bus.redirect_pc, 0);
        chk("rst err", 32'(bus.ras_err), 0);
        chk("rst flags", 32'(bus.flags_q), 0);
        chk("rst cnt", 32'(bus.ras_count), 0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].fwe, vecs[i].fin, vecs[i].bv, vecs[i].op,
                  vecs[i].pc, vecs[i].imm, vecs[i].rs);
            step();
            chk($sformatf("v%0d rv", i), 32'(bus.redirect_valid), 32'(vecs[i].rv));
            if (vecs[i].rv)
                chk($sformatf("v%0d rpc", i), bus.redirect_pc, vecs[i].rpc);
            chk($sformatf("v%0d busy", i), 32'(bus.busy), 32'(vecs[i].busy));
            chk($sformatf("v%0d flush", i), 32'(bus.flush), 32'(vecs[i].busy));
            chk($sformatf("v%0d err", i), 32'(bus.ras_err), 32'(vecs[i].err));
            chk($sformatf("v%0d flags", i), 32'(bus.flags_q), 32'(vecs[i].fq));
            chk($sformatf("v%0d cnt", i), 32'(bus.ras_count), 32'(vecs[i].cnt));
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        step();

        for (int i = 1; i <= 5; i++) begin
            issue(4'd2, 32'(i) << 12, rv, rpc, err);
            chk($sformatf("bl%0d rpc", i), rpc, 32'(i) << 12);
        end
        chk("ovf cnt", 32'(bus.ras_count), 4);
        for (int i = 0; i < 4; i++) begin
            issue(4'd4, 32'h0, rv, rpc, err);
            chk($sformatf("ret%0d rv", i), 32'(rv), 1);
            chk($sformatf("ret%0d rpc", i), rpc, (32'(5 - i) << 12) + 32'h4);
            chk($sformatf("ret%0d err", i), 32'(err), 0);
        end
        chk("pop cnt", 32'(bus.ras_count), 0);
        issue(4'd4, 32'h0, rv, rpc, err);
        chk("udf rv", 32'(rv), 1);
        chk("udf rpc", rpc, 32'h0);
        chk("udf err", 32'(err), 1);
        chk("udf cnt", 32'(bus.ras_count), 0);

        drive(1, 4'hF, 0, 0, 0, 0, 0);
        step();
        drive(0, 0, 1, 4'd2, 32'h600, 16'h0, 32'h0);
        step();
        chk("pre rst busy", 32'(bus.busy), 1);
        chk("pre rst cnt", 32'(bus.ras_count), 1);
        drive(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        step();
        chk("mid rst flush", 32'(bus.flush), 0);
        chk("mid rst busy", 32'(bus.busy), 0);
        chk("mid rst rv", 32'(bus.redirect_valid), 0);
        chk("mid rst cnt", 32'(bus.ras_count), 0);
        chk("mid rst flags", 32'(bus.flags_q), 0);
        rst = 1'b0;
        step();
        chk("post rst rv", 32'(bus.redirect_valid), 0);
        chk("post rst busy", 32'(bus.busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
